// File: rtl/pipeline_ctrl_if.sv
// Hazard/sequencing bundle between the pipeline datapath and pipeline_ctrl.
// master = controller side (reads hazard info, drives forwarding/stall/flush); slave = datapath side.
interface pipeline_ctrl_if;
  logic [4:0] Rs1D, Rs2D;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic [1:0] ResultSrcE;
  logic       PCSrcE;
  logic [4:0] RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic       MemReqM, MemAckM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;
  logic       MemErr;

  modport master (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemAckM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemErr
  );

  modport slave (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemAckM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemErr
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: forwarding, load-use/branch/memory-wait stalls and flushes, timeout watchdog.
// Optional PIPE_PERF_CNT_EN adds StallCycles/FlushCycles/MemWaitCycles performance counters.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  pipeline_ctrl_if.master     hz_if
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]         StallCycles,
  output logic [31:0]         FlushCycles,
  output logic [31:0]         MemWaitCycles
`endif
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_e;

  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             memerr_q, memerr_d;
  logic             mem_stall, lw_stall, hold;

  // Memory-stage result wins over Writeback; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic we_m, input logic [4:0] rd_w,
                                         input logic we_w);
    if (rs != 5'd0 && we_m && rs == rd_m)      return 2'b10;
    else if (rs != 5'd0 && we_w && rs == rd_w) return 2'b01;
    else                                        return 2'b00;
  endfunction

  assign mem_stall = hz_if.MemReqM && !hz_if.MemAckM;
  assign lw_stall  = (hz_if.ResultSrcE == 2'b01) && (hz_if.RdE != 5'd0) &&
                     ((hz_if.RdE == hz_if.Rs1D) || (hz_if.RdE == hz_if.Rs2D));
  // In ERR the acknowledge is ignored and the whole pipeline stays frozen.
  assign hold      = mem_stall || (state_q == S_ERR);

  assign hz_if.ForwardAE = fwd_sel(hz_if.Rs1E, hz_if.RdM, hz_if.RegWriteM, hz_if.RdW, hz_if.RegWriteW);
  assign hz_if.ForwardBE = fwd_sel(hz_if.Rs2E, hz_if.RdM, hz_if.RegWriteM, hz_if.RdW, hz_if.RegWriteW);
  assign hz_if.StallF    = hold || (lw_stall && !hz_if.PCSrcE);
  assign hz_if.StallD    = hold || (lw_stall && !hz_if.PCSrcE);
  assign hz_if.StallE    = hold;
  assign hz_if.StallM    = hold;
  assign hz_if.FlushW    = hold;
  assign hz_if.FlushD    = hz_if.PCSrcE && !hold;
  assign hz_if.FlushE    = (hz_if.PCSrcE || lw_stall) && !hold;
  assign hz_if.MemErr    = memerr_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          state_d    = S_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (!mem_stall) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_TIMEOUT) begin
          state_d    = S_ERR;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_RUN;
    endcase
    memerr_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
      memerr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      memerr_q   <= memerr_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      if (hz_if.StallF)        stall_cnt_q   <= stall_cnt_q + 32'd1;
      if (hz_if.FlushE)        flush_cnt_q   <= flush_cnt_q + 32'd1;
      if (state_q == S_WAIT)   memwait_cnt_q <= memwait_cnt_q + 32'd1;
    end
  end

  assign StallCycles   = stall_cnt_q;
  assign FlushCycles   = flush_cnt_q;
  assign MemWaitCycles = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (MEM_TIMEOUT = 4): forwarding, load-use, branch, memory wait, timeout and reset.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  pipeline_ctrl_if hz();

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] sc, fc, mc;
  logic [31:0] sc0, fc0, mc0;
`endif

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz_if (hz)
`ifdef PIPE_PERF_CNT_EN
    ,
    .StallCycles   (sc),
    .FlushCycles   (fc),
    .MemWaitCycles (mc)
`endif
  );

  always #5 clk = ~clk;

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  function automatic logic [6:0] ctl();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0;
    hz.ResultSrcE = 2'b00; hz.PCSrcE = 0; hz.RdM = 0; hz.RdW = 0;
    hz.RegWriteM = 0; hz.RegWriteW = 0; hz.MemReqM = 0; hz.MemAckM = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    tick(); tick();
    chk("reset_ctl", 32'(ctl()), 32'h0);
    chk("reset_fwd", 32'({hz.ForwardAE, hz.ForwardBE}), 32'h0);
    chk("reset_memerr", 32'(hz.MemErr), 32'h0);
    chk("reset_cnt", 32'(dut.wait_cnt_q), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("idle_ctl", 32'(ctl()), 32'h0);

    // Forwarding
    hz.Rs1E = 5; hz.Rs2E = 5; hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1;
    #1;
    chk("fwdA_mem", 32'(hz.ForwardAE), 32'h2);
    chk("fwdB_mem", 32'(hz.ForwardBE), 32'h2);
    hz.RegWriteM = 0; #1;
    chk("fwdA_wb", 32'(hz.ForwardAE), 32'h1);
    chk("fwdB_wb", 32'(hz.ForwardBE), 32'h1);
    hz.Rs1E = 0; #1;
    chk("fwdA_x0", 32'(hz.ForwardAE), 32'h0);
    chk("fwdB_wb_kept", 32'(hz.ForwardBE), 32'h1);
    hz.RdW = 6; #1;
    chk("fwdB_nomatch", 32'(hz.ForwardBE), 32'h0);
    hz.Rs2E = 9; hz.RdM = 9; hz.RegWriteM = 1; hz.RegWriteW = 0; #1;
    chk("fwdB_mem_only", 32'(hz.ForwardBE), 32'h2);
    clear_inputs();
    tick();

    // Load-use and branch priority
    hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs2D = 7; #1;
    chk("lw_stall", 32'(ctl()), 32'b1100010);
    hz.PCSrcE = 1; #1;
    chk("lw_branch", 32'(ctl()), 32'b0000110);
    hz.PCSrcE = 0; hz.ResultSrcE = 2'b00; #1;
    chk("not_load", 32'(ctl()), 32'h0);
    hz.ResultSrcE = 2'b01; hz.Rs2D = 0; hz.Rs1D = 7; #1;
    chk("lw_rs1", 32'(ctl()), 32'b1100010);
    hz.RdE = 0; hz.Rs1D = 0; #1;
    chk("lw_x0", 32'(ctl()), 32'h0);
    clear_inputs();
    hz.PCSrcE = 1; #1;
    chk("branch_only", 32'(ctl()), 32'b0000110);
    clear_inputs();
    tick();

    // Ack in the same cycle as the request costs nothing
    hz.MemReqM = 1; hz.MemAckM = 1; #1;
    chk("ack_same_ctl", 32'(ctl()), 32'h0);
    tick();
    chk("ack_same_cnt", 32'(dut.wait_cnt_q), 32'h0);
    clear_inputs();
    tick();

    // Memory wait of 3 cycles with a branch held in Execute
`ifdef PIPE_PERF_CNT_EN
    sc0 = sc; fc0 = fc; mc0 = mc;
`endif
    hz.MemReqM = 1; hz.MemAckM = 0; hz.PCSrcE = 1; #1;
    chk("wait1_ctl", 32'(ctl()), 32'b1111001);
    tick();
    chk("wait2_cnt", 32'(dut.wait_cnt_q), 32'h1);
    chk("wait2_ctl", 32'(ctl()), 32'b1111001);
    tick();
    chk("wait3_cnt", 32'(dut.wait_cnt_q), 32'h2);
    chk("wait3_ctl", 32'(ctl()), 32'b1111001);
    tick();
    hz.MemAckM = 1; #1;
    chk("wait_ack_ctl", 32'(ctl()), 32'b0000110);
    tick();
    clear_inputs(); #1;
    chk("wait_done_cnt", 32'(dut.wait_cnt_q), 32'h0);
    chk("wait_done_ctl", 32'(ctl()), 32'h0);
`ifdef PIPE_PERF_CNT_EN
    chk("perf_stall", sc - sc0, 32'd3);
    chk("perf_memwait", mc - mc0, 32'd3);
    chk("perf_flush", fc - fc0, 32'd1);
`endif
    tick();

    // Ack arriving in the timeout cycle wins
    hz.MemReqM = 1; hz.MemAckM = 0;
    tick(); tick(); tick(); tick();
    chk("edge_cnt4", 32'(dut.wait_cnt_q), 32'h4);
    chk("edge_memerr", 32'(hz.MemErr), 32'h0);
    hz.MemAckM = 1; #1;
    chk("edge_ack_ctl", 32'(ctl()), 32'h0);
    tick();
    chk("edge_ack_memerr", 32'(hz.MemErr), 32'h0);
    chk("edge_ack_cnt", 32'(dut.wait_cnt_q), 32'h0);
    clear_inputs();
    tick();

    // Timeout into ERR
    hz.MemReqM = 1; hz.MemAckM = 0;
    tick(); tick(); tick(); tick();
    chk("to_memerr_before", 32'(hz.MemErr), 32'h0);
    chk("to_ctl_before", 32'(ctl()), 32'b1111001);
    tick();
    chk("to_memerr", 32'(hz.MemErr), 32'h1);
    chk("to_ctl", 32'(ctl()), 32'b1111001);
    hz.MemAckM = 1; hz.PCSrcE = 1; #1;
    chk("err_ack_ignored", 32'(ctl()), 32'b1111001);
    tick();
    chk("err_sticky", 32'(hz.MemErr), 32'h1);
    hz.PCSrcE = 0; hz.MemReqM = 0; hz.MemAckM = 0; #1;
    chk("err_noreq_ctl", 32'(ctl()), 32'b1111001);
    hz.MemReqM = 1; hz.MemAckM = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("err_rst_ctl", 32'(ctl()), 32'h0);
    chk("err_rst_memerr", 32'(hz.MemErr), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("err_after_rst_ctl", 32'(ctl()), 32'h0);
    chk("err_after_rst_memerr", 32'(hz.MemErr), 32'h0);
    clear_inputs();
    tick();

    // Reset asserted mid-wait
    hz.MemReqM = 1; hz.MemAckM = 0;
    tick(); tick();
    chk("midwait_cnt", 32'(dut.wait_cnt_q), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("midwait_rst_cnt", 32'(dut.wait_cnt_q), 32'h0);
    chk("midwait_rst_memerr", 32'(hz.MemErr), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("midwait_restart_cnt", 32'(dut.wait_cnt_q), 32'h1);
    hz.MemAckM = 1; #1;
    chk("midwait_ack_ctl", 32'(ctl()), 32'h0);
    tick();
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage pipeline. Generates forwarding selects for the Execute stage, and stall/flush enables for the Fetch, Decode, Execute, Memory and Writeback pipeline registers. Covers load-use hazards, taken-branch flushes and variable-latency data-memory waits, with a watchdog that locks the pipeline on a memory timeout. It sits beside the datapath and drives the enable/clear inputs of every pipeline register, including the Memory-to-Writeback register.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive wait cycles for one memory access before the error state.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  5  source registers in Decode.
- Rs1E, Rs2E, RdE  in  5  source and destination registers in Execute.
- ResultSrcE  in  2  Execute result source; 2'b01 marks a load.
- PCSrcE  in  1  taken branch or jump resolved in Execute.
- RdM, RdW  in  5  destination registers in Memory and Writeback.
- RegWriteM, RegWriteW  in  1  register-write enables in Memory and Writeback.
- MemReqM  in  1  load or store active in Memory.
- MemAckM  in  1  data memory completes the access this cycle.
- ForwardAE, ForwardBE  out  2  00 = register file, 10 = ALUOutM, 01 = Writeback result.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1  load a bubble (all control zero) into the register.
- MemErr  out  1  sticky memory-timeout flag.

## Operation
- **Forwarding** (combinational), shown for A; B is identical using Rs2E:
  - If Rs1E != 0 && RegWriteM && Rs1E == RdM, select 10.
  - Else if Rs1E != 0 && RegWriteW && Rs1E == RdW, select 01.
  - Else select 00.
  - Memory takes priority over Writeback.
- **Load-use hazard**: lwStall = (ResultSrcE == 01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D).
  - Response: StallF = StallD = 1 and FlushE = 1.
- **Branch**: PCSrcE produces FlushD = FlushE = 1.
  - Branch beats load-use: StallF and StallD are 0 when PCSrcE is 1.
- **Memory wait**: memStall = MemReqM && !MemAckM.
  - Response: StallF = StallD = StallE = StallM = 1 and FlushW = 1.
  - FlushD and FlushE are suppressed, so a branch sitting in Execute is held and takes effect once the wait ends.
- **State machine**: RUN, WAIT, ERR.
  - RUN goes to WAIT when memStall; WaitCnt is loaded with 1.
  - WAIT goes to RUN when MemAckM or !MemReqM; WaitCnt is cleared.
  - WAIT stays in WAIT while memStall; WaitCnt increments.
  - WAIT goes to ERR when memStall && WaitCnt == MEM_TIMEOUT.
  - ERR is absorbing until reset. In ERR, all Stall outputs and FlushW are 1, MemErr is 1, and MemAckM is ignored.
- WaitCnt saturates and never wraps.

## Timing
- Reset (asynchronous, rst_n low): state is RUN, WaitCnt is 0, MemErr is 0.
- After reset, every other output is a pure combinational function of the inputs. With all inputs at zero, all outputs are 0.
- Forwarding, stall and flush outputs have zero-cycle latency from their inputs.
- MemErr is registered and asserts on the clock edge that enters ERR.
- Memory handshake:
  - MemReqM must stay asserted while StallM is 1.
  - An ack in the same cycle as the request costs no stall cycles.
  - An ack after N wait cycles costs exactly N stall cycles.
- Timeout: with MemAckM held low, ERR is entered on the edge ending wait cycle MEM_TIMEOUT + 1.
  - An ack in that same cycle wins: the FSM returns to RUN.
- Reset asserted mid-wait or in ERR: outputs return immediately to their combinational values, with no residual stall.

## Configuration
- PIPE_PERF_CNT_EN defined: adds three outputs, each a 32-bit counter that resets to 0 and wraps modulo 2^32:
  - StallCycles: cycles with StallF == 1.
  - FlushCycles: cycles with FlushE == 1.
  - MemWaitCycles: cycles in WAIT.
- PIPE_PERF_CNT_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Forwarding:
  - Rs1E = 5, RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1 gives ForwardAE = 10.
  - Clearing RegWriteM gives ForwardAE = 01.
  - Rs1E = 0 gives ForwardAE = 00.
- Load-use: ResultSrcE = 01, RdE = 7, Rs2D = 7 gives StallF = StallD = FlushE = 1 for one cycle. Adding PCSrcE = 1 gives FlushD = FlushE = 1 and StallF = StallD = 0.
- Memory wait: MemReqM = 1, with MemAckM rising after 3 cycles:
  - StallF/D/E/M = 1 and FlushW = 1 for exactly 3 cycles, then all 0.
  - A concurrent PCSrcE = 1 produces no flush until the cycle of the ack.
- Timeout, with MEM_TIMEOUT = 4 and MemAckM held low: MemErr rises after the 5th wait cycle and all stalls stay high. A later MemAckM = 1 has no effect until rst_n is pulsed low.
- Reset mid-wait: pull rst_n low asynchronously during WAIT. Outputs drop immediately, WaitCnt is 0, and MemErr is 0.
- With PIPE_PERF_CNT_EN: run the memory-wait scenario and check MemWaitCycles = 3 and StallCycles = 3.
